// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its helpers.
package muldiv_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } muldiv_state_t;

  // Operation select encoding on req_op
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Default bound on the number of WAIT cycles
  localparam int unsigned MULDIV_TIMEOUT_DEFAULT = 64;

  // A DIV with a zero divisor never reaches the engine
  function automatic logic is_div_by_zero(input logic op, input logic divisor_zero);
    return (op == OP_DIV) && divisor_zero;
  endfunction

endpackage

// File: rtl/muldiv_wait_cnt.sv
// Saturating wait counter: cleared on clr, counts on en, holds at TIMEOUT-1.
module muldiv_wait_cnt
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = MULDIV_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until the last value
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Owns the shared multiplier/divider pair and the HI/LO write path: accepts
// one MULT/DIV request, starts the selected engine, waits (bounded) for its
// result and commits HI/LO in a single cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = MULDIV_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             mult_start,
  output logic             div_start,
  input  logic             mult_ready,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             hi_wr,
  output logic             lo_wr,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data,
  output logic             done,
  output logic             div_zero,
  output logic             timeout,
  output logic             busy
);

  muldiv_state_t state_q, state_d;

  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Pulse outputs are flops loaded from the next-state decode, so they are
  // glitch-free and forced low by the same reset that sends state to IDLE.
  logic mult_start_q, mult_start_d;
  logic div_start_q,  div_start_d;
  logic write_q,      write_d;
  logic div_zero_q,   div_zero_d;
  logic timeout_q,    timeout_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_expired;
  logic [CNT_W-1:0] cnt_count;
  logic             sel_ready;
  logic             unused_cnt;

  muldiv_wait_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cnt_count),
    .expired (cnt_expired)
  );

  // Only the expiry flag steers the FSM; the raw count is for observation
  assign unused_cnt = ^cnt_count;

  // Only the engine selected by the latched op may complete the operation
  assign sel_ready = (op_q == OP_DIV) ? div_ready : mult_ready;

  // Next-state, datapath capture and pulse decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    write_d      = 1'b0;
    div_zero_d   = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (is_div_by_zero(req_op, req_b == '0)) begin
            state_d    = ST_ERR;
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_START;
            if (req_op == OP_DIV) begin
              div_start_d = 1'b1;
            end else begin
              mult_start_d = 1'b1;
            end
          end
        end
      end
      ST_START: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (sel_ready) begin
          if (op_q == OP_DIV) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mult_hi;
            lo_d = mult_lo;
          end
          state_d = ST_WRITE;
          write_d = 1'b1;
        end else if (cnt_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand/result latches and registered pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MULT;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      write_q      <= 1'b0;
      div_zero_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      write_q      <= write_d;
      div_zero_q   <= div_zero_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign eng_a      = a_q;
  assign eng_b      = b_q;
  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign hi_wr      = write_q;
  assign lo_wr      = write_q;
  assign done       = write_q;
  assign hi_data    = hi_q;
  assign lo_data    = lo_q;
  assign div_zero   = div_zero_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: default instance (TIMEOUT=64) plus a
// TIMEOUT=8 instance sharing the same stimulus for the timeout case.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  // Flag vector: {req_ready, busy, mult_start, div_start, hi_wr, lo_wr, done, div_zero, timeout}
  localparam logic [8:0] F_IDLE    = 9'b100000000;
  localparam logic [8:0] F_START_M = 9'b011000000;
  localparam logic [8:0] F_START_D = 9'b010100000;
  localparam logic [8:0] F_WAIT    = 9'b010000000;
  localparam logic [8:0] F_WRITE   = 9'b010011100;
  localparam logic [8:0] F_ERR     = 9'b010000010;
  localparam logic [8:0] F_TO      = 9'b100000001;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_op;
  logic [W-1:0] req_a, req_b;
  logic         mult_ready, div_ready;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;

  logic         req_ready, mult_start, div_start, hi_wr, lo_wr, done, div_zero, timeout, busy;
  logic [W-1:0] eng_a, eng_b, hi_data, lo_data;

  logic         t8_req_ready, t8_mult_start, t8_div_start, t8_hi_wr, t8_lo_wr, t8_done;
  logic         t8_div_zero, t8_timeout, t8_busy;
  logic [W-1:0] t8_eng_a, t8_eng_b, t8_hi_data, t8_lo_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .eng_a(eng_a), .eng_b(eng_b),
    .mult_start(mult_start), .div_start(div_start),
    .mult_ready(mult_ready), .div_ready(div_ready),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_data(hi_data), .lo_data(lo_data),
    .done(done), .div_zero(div_zero), .timeout(timeout), .busy(busy)
  );

  muldiv_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(t8_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .eng_a(t8_eng_a), .eng_b(t8_eng_b),
    .mult_start(t8_mult_start), .div_start(t8_div_start),
    .mult_ready(mult_ready), .div_ready(div_ready),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_wr(t8_hi_wr), .lo_wr(t8_lo_wr), .hi_data(t8_hi_data), .lo_data(t8_lo_data),
    .done(t8_done), .div_zero(t8_div_zero), .timeout(t8_timeout), .busy(t8_busy)
  );

  function automatic logic [8:0] flags();
    return {req_ready, busy, mult_start, div_start, hi_wr, lo_wr, done, div_zero, timeout};
  endfunction

  function automatic logic [8:0] flags8();
    return {t8_req_ready, t8_busy, t8_mult_start, t8_div_start, t8_hi_wr, t8_lo_wr,
            t8_done, t8_div_zero, t8_timeout};
  endfunction

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = OP_MULT; req_a = '0; req_b = '0;
    mult_ready = 1'b0; div_ready = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    step(); step();

    // Reset state
    chk("rst_flags", 64'(flags()), 64'(F_IDLE));
    chk("rst_eng_a", 64'(eng_a), 64'd0);
    chk("rst_hi_data", 64'(hi_data), 64'd0);
    chk("rst_lo_data", 64'(lo_data), 64'd0);
    reset = 1'b1;
    step();
    chk("idle_flags", 64'(flags()), 64'(F_IDLE));

    // MULT with engine ready on first WAIT cycle
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd7; req_b = 32'd6;
    step();
    chk("mul_t1_flags", 64'(flags()), 64'(F_START_M));
    chk("mul_eng_a", 64'(eng_a), 64'd7);
    chk("mul_eng_b", 64'(eng_b), 64'd6);
    req_valid = 1'b0;
    step();
    chk("mul_t2_flags", 64'(flags()), 64'(F_WAIT));
    mult_ready = 1'b1; mult_hi = 32'd0; mult_lo = 32'd42;
    step();
    chk("mul_t3_flags", 64'(flags()), 64'(F_WRITE));
    chk("mul_lo_data", 64'(lo_data), 64'd42);
    chk("mul_hi_data", 64'(hi_data), 64'd0);
    mult_ready = 1'b0;
    step();
    chk("mul_t4_flags", 64'(flags()), 64'(F_IDLE));

    // DIV with 32 idle WAIT cycles, mult_ready glitching meanwhile
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
    mult_hi = 32'hdead; mult_lo = 32'hbeef;
    step();
    chk("div_t1_flags", 64'(flags()), 64'(F_START_D));
    chk("div_eng_a", 64'(eng_a), 64'd100);
    chk("div_eng_b", 64'(eng_b), 64'd7);
    req_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("div_wait_flags", 64'(flags()), 64'(F_WAIT));
      mult_ready = (i % 3) != 2;
    end
    step();
    chk("div_wait33_flags", 64'(flags()), 64'(F_WAIT));
    mult_ready = 1'b0; div_ready = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
    step();
    chk("div_write_flags", 64'(flags()), 64'(F_WRITE));
    chk("div_lo_data", 64'(lo_data), 64'd14);
    chk("div_hi_data", 64'(hi_data), 64'd2);
    div_ready = 1'b0;
    step();
    chk("div_end_flags", 64'(flags()), 64'(F_IDLE));

    // DIV by zero
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd5; req_b = 32'd0;
    step();
    chk("dz_t1_flags", 64'(flags()), 64'(F_ERR));
    chk("dz_eng_a", 64'(eng_a), 64'd5);
    req_valid = 1'b0;
    step();
    chk("dz_t2_flags", 64'(flags()), 64'(F_IDLE));
    chk("dz_hi_kept", 64'(hi_data), 64'd2);
    step();
    chk("dz_t3_flags", 64'(flags()), 64'(F_IDLE));

    // req_valid held high across a whole operation and into the next
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd5;
    step();
    chk("hs_start_flags", 64'(flags()), 64'(F_START_M));
    req_a = 32'd9; req_b = 32'd5;
    step();
    chk("hs_wait_flags", 64'(flags()), 64'(F_WAIT));
    chk("hs_eng_a_stable", 64'(eng_a), 64'd3);
    mult_ready = 1'b1; mult_hi = 32'd0; mult_lo = 32'd15;
    step();
    chk("hs_write_flags", 64'(flags()), 64'(F_WRITE));
    chk("hs_lo_data", 64'(lo_data), 64'd15);
    chk("hs_eng_a_wr", 64'(eng_a), 64'd3);
    mult_ready = 1'b0;
    step();
    chk("hs_idle_flags", 64'(flags()), 64'(F_IDLE));
    step();
    chk("hs_start2_flags", 64'(flags()), 64'(F_START_M));
    chk("hs_eng_a2", 64'(eng_a), 64'd9);
    req_valid = 1'b0;
    step();
    chk("hs_wait2_flags", 64'(flags()), 64'(F_WAIT));
    mult_ready = 1'b1; mult_hi = 32'd0; mult_lo = 32'd45;
    step();
    chk("hs_write2_flags", 64'(flags()), 64'(F_WRITE));
    chk("hs_lo_data2", 64'(lo_data), 64'd45);
    mult_ready = 1'b0;
    step();
    chk("hs_end_flags", 64'(flags()), 64'(F_IDLE));

    // Reset during the 3rd WAIT cycle, engine ready right after
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd1; req_b = 32'd1;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("rw_wait3_flags", 64'(flags()), 64'(F_WAIT));
    reset = 1'b0;
    step();
    chk("rw_rst_flags", 64'(flags()), 64'(F_IDLE));
    chk("rw_eng_a", 64'(eng_a), 64'd0);
    chk("rw_eng_b", 64'(eng_b), 64'd0);
    chk("rw_lo_data", 64'(lo_data), 64'd0);
    reset = 1'b1;
    mult_ready = 1'b1; mult_hi = 32'd1; mult_lo = 32'd77;
    step();
    chk("rw_after1_flags", 64'(flags()), 64'(F_IDLE));
    chk("rw_after1_lo", 64'(lo_data), 64'd0);
    mult_ready = 1'b0;
    step();
    chk("rw_after2_flags", 64'(flags()), 64'(F_IDLE));

    // Timeout on the TIMEOUT=8 instance
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("to_rst_flags", 64'(flags8()), 64'(F_IDLE));
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd2; req_b = 32'd3;
    step();
    chk("to_start_flags", 64'(flags8()), 64'(F_START_M));
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_wait_flags", 64'(flags8()), 64'(F_WAIT));
    end
    step();
    chk("to_pulse_flags", 64'(flags8()), 64'(F_TO));
    chk("to_lo_data", 64'(t8_lo_data), 64'd0);
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd4; req_b = 32'd5;
    step();
    chk("to_next_start", 64'(flags8()), 64'(F_START_M));
    chk("to_next_eng_a", 64'(t8_eng_a), 64'd4);
    req_valid = 1'b0;
    step();
    chk("to_next_wait", 64'(flags8()), 64'(F_WAIT));
    mult_ready = 1'b1; mult_hi = 32'd0; mult_lo = 32'd20;
    step();
    chk("to_next_write", 64'(flags8()), 64'(F_WRITE));
    chk("to_next_lo", 64'(t8_lo_data), 64'd20);
    mult_ready = 1'b0;
    step();
    chk("to_next_idle", 64'(flags8()), 64'(F_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
